// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder.
//
// Contents:
//   state_t      - decoder FSM states (ST_INIT, ST_TRACK)
//   dec_t        - classification of one filtered phase-pair transition
//   PH_*         - phase-pair constants, written as {A, B}
//   phase_index  - position of a phase pair along the up-count Gray cycle
//   decode_step  - classifies a (prev, cur) pair as none / up / down / illegal
package quad_pkg;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_TRACK
    } state_t;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_UP,
        DEC_DOWN,
        DEC_ILLEGAL
    } dec_t;

    // Phase pairs as {A, B}; up-count order is 00 -> 10 -> 11 -> 01 -> 00.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Maps each phase pair onto its slot in the up-count cycle so a transition
    // becomes a modulo-4 difference.
    function automatic logic [1:0] phase_index(input logic [1:0] ph);
        logic [1:0] idx;
        case (ph)
            PH_00:   idx = 2'd0;
            PH_10:   idx = 2'd1;
            PH_11:   idx = 2'd2;
            default: idx = 2'd3; // PH_01
        endcase
        return idx;
    endfunction

    // Difference of +1 is an up step, -1 (3) a down step, 0 no movement and
    // 2 means both phases flipped at once, which has no defined direction.
    function automatic dec_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] diff;
        dec_t       res;
        diff = phase_index(cur) - phase_index(prev);
        case (diff)
            2'd0:    res = DEC_NONE;
            2'd1:    res = DEC_UP;
            2'd3:    res = DEC_DOWN;
            default: res = DEC_ILLEGAL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/phase_filter.sv
// Synchronizer and stability filter for one raw quadrature phase.
//
// The raw pin passes through a two-flop synchronizer. The filtered value only
// follows the synchronized value after the two have disagreed for FILTER_LEN
// consecutive cycles; any agreement in between restarts the count, so short
// glitches never reach the filtered output.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   raw       in   raw phase pin, asynchronous to clk
//   load      in   force filtered value to the synchronized value now
//   synced    out  second synchronizer stage
//   filtered  out  debounced phase value
module phase_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic load,
    output logic synced,
    output logic filtered
);

    // Reaching FILTER_LEN-1 with a mismatch still present means this is the
    // FILTER_LEN-th differing cycle, so the filtered value updates here.
    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (load) begin
                filt_q <= sync2_q;
                cnt_q  <= 8'd0;
            end else if (sync2_q == filt_q) begin
                cnt_q <= 8'd0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= sync2_q;
                cnt_q  <= 8'd0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign synced   = sync2_q;
    assign filtered = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder with wrapping position counter.
//
// Both phases are synchronized and glitch-filtered, then each change of the
// filtered {A, B} pair is decoded into an up step, a down step, or an illegal
// double-bit jump. Legal steps move POS and pulse STEP for one cycle; illegal
// jumps set the sticky ERR flag. After reset the decoder waits for the
// synchronizers to fill, then adopts the current pin levels as its starting
// phase without decoding, so a resting encoder never produces a spurious step.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST_N    in   synchronous active-low reset
//   QA, QB   in   raw encoder phases, asynchronous to CLK
//   CLR      in   synchronous clear of POS (wins over a same-cycle step)
//   ERR_CLR  in   synchronous clear of ERR (loses to a same-cycle illegal jump)
//   POS      out  position, modulo 2^CNT_W
//   STEP     out  one-cycle pulse per legal transition
//   DIR      out  direction of last legal step, 1 = up
//   ERR      out  sticky illegal-transition flag
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             QA,
    input  logic             QB,
    input  logic             CLR,
    input  logic             ERR_CLR,
    output logic [CNT_W-1:0] POS,
    output logic             STEP,
    output logic             DIR,
    output logic             ERR
);

    // INIT lasts FILTER_LEN+2 cycles: counter runs 0 .. FILTER_LEN+1.
    localparam logic [8:0]       INIT_LAST = 9'(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] POS_ONE   = CNT_W'(1);

    logic             sync_a;
    logic             sync_b;
    logic             filt_a;
    logic             filt_b;
    logic             load_init;
    logic [1:0]       cur_ph;
    dec_t             dec;

    state_t           state_q;
    logic [8:0]       init_cnt_q;
    logic [1:0]       prev_q;
    logic [CNT_W-1:0] pos_q;
    logic             step_q;
    logic             dir_q;
    logic             err_q;

    phase_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_a (
        .clk      (CLK),
        .rst_n    (RST_N),
        .raw      (QA),
        .load     (load_init),
        .synced   (sync_a),
        .filtered (filt_a)
    );

    phase_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_b (
        .clk      (CLK),
        .rst_n    (RST_N),
        .raw      (QB),
        .load     (load_init),
        .synced   (sync_b),
        .filtered (filt_b)
    );

    assign load_init = (state_q == ST_INIT) && (init_cnt_q == INIT_LAST);
    assign cur_ph    = {filt_a, filt_b};
    assign dec       = decode_step(prev_q, cur_ph);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 9'd0;
            prev_q     <= PH_00;
            pos_q      <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            step_q <= 1'b0;

            case (state_q)
                ST_INIT: begin
                    if (load_init) begin
                        // Filters load the same synchronized pair this edge, so
                        // the first TRACK cycle sees prev == cur.
                        prev_q     <= {sync_a, sync_b};
                        init_cnt_q <= 9'd0;
                        state_q    <= ST_TRACK;
                    end else begin
                        init_cnt_q <= init_cnt_q + 9'd1;
                    end
                end

                ST_TRACK: begin
                    prev_q <= cur_ph;
                    unique case (dec)
                        DEC_NONE: ;
                        DEC_UP: begin
                            pos_q  <= pos_q + POS_ONE;
                            dir_q  <= 1'b1;
                            step_q <= 1'b1;
                        end
                        DEC_DOWN: begin
                            pos_q  <= pos_q - POS_ONE;
                            dir_q  <= 1'b0;
                            step_q <= 1'b1;
                        end
                        DEC_ILLEGAL: begin
                            err_q <= 1'b1;
                        end
                    endcase
                end

                default: begin
                    state_q <= ST_INIT;
                end
            endcase

            // Later assignment overrides any step taken above.
            if (CLR) begin
                pos_q <= '0;
            end

            // A fresh illegal jump in the same cycle keeps the flag set.
            if (ERR_CLR && !((state_q == ST_TRACK) && (dec == DEC_ILLEGAL))) begin
                err_q <= 1'b0;
            end
        end
    end

    assign POS  = pos_q;
    assign STEP = step_q;
    assign DIR  = dir_q;
    assign ERR  = err_q;

endmodule
